// File: rtl/fetch_stage.sv
// Instruction fetch stage.
// Issues one read at a time to instruction memory and holds the returned
// instruction for the IF/ID buffer until the pipeline consumes it.
// Redirects from EX squash younger fetch work. A read that is still in
// flight when a redirect arrives is drained in DISCARD, so that its late
// response is never mistaken for the instruction at the new target.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h00000060,
    parameter logic [31:0] NOP_INST = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] inst_mem_address,
    output logic        inst_mem_read,
    input  logic [31:0] inst_mem_rdata,
    input  logic        inst_mem_resp,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst
);

    // The memory interface is word addressed, so the reset address is
    // forced to a word boundary in the same way as redirect targets.
    localparam logic [31:0] RESET_ADDR = RESET_PC & 32'hFFFF_FFFC;

    // FETCH:   a read is outstanding and its data will be kept.
    // HOLD:    an instruction is held for downstream; no read is issued.
    // DISCARD: a read is outstanding but was squashed; its data is dropped.
    typedef enum logic [1:0] {
        FETCH   = 2'b00,
        HOLD    = 2'b01,
        DISCARD = 2'b10
    } fetch_state_t;

    fetch_state_t state, state_next;

    logic [31:0] req_addr, req_addr_next;
    logic [31:0] pending_pc, pending_pc_next;
    logic        valid_q, valid_next;
    logic [31:0] pc_q, pc_next;
    logic [31:0] inst_q, inst_next;
    logic [31:0] redirect_target;

    // Redirect targets are word aligned; the low two bits are dropped.
    assign redirect_target = redirect_pc & 32'hFFFF_FFFC;

    // A read is requested whenever a response is expected, except while
    // reset is held, which abandons any outstanding read immediately.
    assign inst_mem_read    = ((state == FETCH) || (state == DISCARD)) && !rst;
    assign inst_mem_address = req_addr;

    assign if_valid = valid_q;
    assign if_pc    = pc_q;
    assign if_inst  = inst_q;

    // Next-state and next-register logic; every register holds by default.
    always_comb begin
        state_next      = state;
        req_addr_next   = req_addr;
        pending_pc_next = pending_pc;
        valid_next      = valid_q;
        pc_next         = pc_q;
        inst_next       = inst_q;

        case (state)
            FETCH: begin
                if (inst_mem_resp) begin
                    if (redirect) begin
                        // Response belongs to the squashed path; the read
                        // is already complete, so restart at the target.
                        req_addr_next = redirect_target;
                    end else begin
                        inst_next     = inst_mem_rdata;
                        pc_next       = req_addr;
                        valid_next    = 1'b1;
                        req_addr_next = req_addr + 32'd4;
                        state_next    = HOLD;
                    end
                end else if (redirect) begin
                    // The address must stay stable until the response, so
                    // the target waits in pending_pc while the read drains.
                    pending_pc_next = redirect_target;
                    state_next      = DISCARD;
                end
            end

            DISCARD: begin
                if (redirect) begin
                    pending_pc_next = redirect_target;
                end
                if (inst_mem_resp) begin
                    // The most recent redirect wins, even when it arrives
                    // together with the response being dropped.
                    req_addr_next = redirect ? redirect_target : pending_pc;
                    state_next    = FETCH;
                end
            end

            HOLD: begin
                if (redirect) begin
                    // Redirect beats stall: the held instruction is younger
                    // than the branch and must not reach decode.
                    valid_next    = 1'b0;
                    inst_next     = NOP_INST;
                    req_addr_next = redirect_target;
                    state_next    = FETCH;
                end else if (!stall) begin
                    // Consumed at this edge; req_addr already points at the
                    // sequential successor.
                    valid_next = 1'b0;
                    inst_next  = NOP_INST;
                    state_next = FETCH;
                end
            end

            default: begin
                state_next = FETCH;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= FETCH;
            req_addr   <= RESET_ADDR;
            pending_pc <= RESET_ADDR;
            valid_q    <= 1'b0;
            pc_q       <= RESET_ADDR;
            inst_q     <= NOP_INST;
        end else begin
            state      <= state_next;
            req_addr   <= req_addr_next;
            pending_pc <= pending_pc_next;
            valid_q    <= valid_next;
            pc_q       <= pc_next;
            inst_q     <= inst_next;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: a cycle-by-cycle vector table covering reset,
// hold/stall, redirects in every state and PC wrap, followed by a
// back-to-back fetch sequence driven by a small memory responder.
// Instructions handed downstream are matched against a scoreboard queue.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [31:0] inst_mem_address;
    logic        inst_mem_read;
    logic [31:0] inst_mem_rdata = 32'h0;
    logic        inst_mem_resp = 1'b0;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;

    int checks = 0;
    int fails  = 0;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic        resp;
        logic [31:0] rdata;
        logic        e_read;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
        logic        push;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];

    fetch_stage #(
        .RESET_PC(32'h00000060),
        .NOP_INST(NOP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .stall(stall),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
        .inst_mem_address(inst_mem_address),
        .inst_mem_read(inst_mem_read),
        .inst_mem_rdata(inst_mem_rdata),
        .inst_mem_resp(inst_mem_resp),
        .if_valid(if_valid),
        .if_pc(if_pc),
        .if_inst(if_inst)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    // Hard time limit so the bench can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        rst            = v.rst;
        stall          = v.stall;
        redirect       = v.redir;
        redirect_pc    = v.rpc;
        inst_mem_resp  = v.resp;
        inst_mem_rdata = v.rdata;
    endtask

    function automatic void add(input logic r, input logic s, input logic rd, input logic [31:0] rpc,
                                input logic rs, input logic [31:0] dat, input logic er, input logic [31:0] ea,
                                input logic ev, input logic [31:0] ep, input logic [31:0] ei, input logic p);
        vec_t v;
        v.rst = r; v.stall = s; v.redir = rd; v.rpc = rpc; v.resp = rs; v.rdata = dat;
        v.e_read = er; v.e_addr = ea; v.e_valid = ev; v.e_pc = ep; v.e_inst = ei; v.push = p;
        vecs.push_back(v);
    endfunction

    // Scoreboard monitor: each new instruction presented downstream must
    // match the oldest expected {pc, inst}.
    logic last_valid = 1'b0;
    always @(negedge clk) begin
        if (if_valid === 1'b1 && !last_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("[TB] FAIL sb_unexpected: got pc %h inst %h expected none", if_pc, if_inst);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checkOutput("sb_pc", if_pc, e.pc);
                checkOutput("sb_inst", if_inst, e.inst);
            end
        end
        last_valid = (if_valid === 1'b1);
    end

    // Memory responder for the back-to-back sequence: waits (bounded) for a
    // read, checks its address and the idle gap, then answers in one cycle.
    task automatic fetch_one(input logic [31:0] data, input logic [31:0] exp_addr, input int exp_wait);
        int waited;
        waited = 0;
        @(negedge clk);
        while (inst_mem_read !== 1'b1 && waited < 10) begin
            @(posedge clk); #1;
            @(negedge clk);
            waited++;
        end
        checkOutput($sformatf("b2b_read_%h", exp_addr), {31'b0, inst_mem_read}, 32'd1);
        checkOutput($sformatf("b2b_addr_%h", exp_addr), inst_mem_address, exp_addr);
        checkOutput($sformatf("b2b_gap_%h", exp_addr), waited, exp_wait);
        exp_q.push_back('{pc: exp_addr, inst: data});
        inst_mem_resp  = 1'b1;
        inst_mem_rdata = data;
        @(posedge clk); #1;
        inst_mem_resp  = 1'b0;
    endtask

    initial begin
        // rst stall redir rpc resp rdata | read addr valid pc inst push
        add(1,1,1,32'h400,1,32'h0BAD0BAD,     0,32'h0,       0,32'h0,       NOP,0);         // 0 reset ignores redirect/resp
        add(0,0,0,32'h0,0,32'h0,              1,32'h60,      0,32'h0,       NOP,0);         // 1 first read at RESET_PC
        add(0,0,0,32'h0,0,32'h0,              1,32'h60,      0,32'h0,       NOP,0);         // 2
        add(0,0,0,32'h0,1,32'h00500093,       1,32'h60,      0,32'h0,       NOP,1);         // 3 resp 2 cycles later
        add(0,0,0,32'h0,0,32'h0,              0,32'h0,       1,32'h60,      32'h00500093,0);// 4 hold, consumed
        add(0,0,0,32'h0,1,32'h11111111,       1,32'h64,      0,32'h0,       NOP,1);         // 5 next read at +4
        add(0,1,0,32'h0,0,32'h0,              0,32'h0,       1,32'h64,      32'h11111111,0);// 6 stall
        add(0,1,0,32'h0,1,32'hEEEEEEEE,       0,32'h0,       1,32'h64,      32'h11111111,0);// 7 resp ignored in hold
        add(0,1,0,32'h0,1,32'hEEEEEEEE,       0,32'h0,       1,32'h64,      32'h11111111,0);// 8
        add(0,1,0,32'h0,1,32'hEEEEEEEE,       0,32'h0,       1,32'h64,      32'h11111111,0);// 9
        add(0,1,0,32'h0,1,32'hEEEEEEEE,       0,32'h0,       1,32'h64,      32'h11111111,0);// 10
        add(0,0,0,32'h0,0,32'h0,              0,32'h0,       1,32'h64,      32'h11111111,0);// 11 stall drops
        add(0,0,1,32'h203,0,32'h0,            1,32'h68,      0,32'h0,       NOP,0);         // 12 redirect, no resp
        add(0,0,0,32'h0,0,32'h0,              1,32'h68,      0,32'h0,       NOP,0);         // 13 discard keeps addr
        add(0,0,0,32'h0,0,32'h0,              1,32'h68,      0,32'h0,       NOP,0);         // 14
        add(0,0,0,32'h0,1,32'hDEADBEEF,       1,32'h68,      0,32'h0,       NOP,0);         // 15 stale resp dropped
        add(0,0,1,32'h100,1,32'hCAFEF00D,     1,32'h200,     0,32'h0,       NOP,0);         // 16 redirect with resp
        add(0,0,0,32'h0,1,32'h22222222,       1,32'h100,     0,32'h0,       NOP,1);         // 17
        add(0,1,1,32'h304,0,32'h0,            0,32'h0,       1,32'h100,     32'h22222222,0);// 18 redirect beats stall
        add(0,0,1,32'h500,0,32'h0,            1,32'h304,     0,32'h0,       NOP,0);         // 19 into discard
        add(0,0,1,32'h600,0,32'h0,            1,32'h304,     0,32'h0,       NOP,0);         // 20 pending overwritten
        add(0,0,1,32'h703,1,32'h77777777,     1,32'h304,     0,32'h0,       NOP,0);         // 21 latest wins with resp
        add(0,0,1,32'hFFFFFFFF,1,32'h88888888,1,32'h700,     0,32'h0,       NOP,0);         // 22
        add(0,0,0,32'h0,1,32'h33333333,       1,32'hFFFFFFFC,0,32'h0,       NOP,1);         // 23 top of memory
        add(0,0,0,32'h0,0,32'h0,              0,32'h0,       1,32'hFFFFFFFC,32'h33333333,0);// 24
        add(0,0,0,32'h0,0,32'h0,              1,32'h0,       0,32'h0,       NOP,0);         // 25 wrapped to 0
        add(1,0,0,32'h0,1,32'h44444444,       0,32'h0,       0,32'h0,       NOP,0);         // 26 reset mid-read
        add(0,0,0,32'h0,0,32'h0,              1,32'h60,      0,32'h0,       NOP,0);         // 27 fresh read
        add(0,0,0,32'h0,1,32'h55555555,       1,32'h60,      0,32'h0,       NOP,1);         // 28
        add(0,0,0,32'h0,0,32'h0,              0,32'h0,       1,32'h60,      32'h55555555,0);// 29
        add(0,0,0,32'h0,0,32'h0,              1,32'h64,      0,32'h0,       NOP,0);         // 30

        // Initial reset: two edges before the table starts.
        rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            @(negedge clk);
            checkOutput($sformatf("row%0d_read", i), {31'b0, inst_mem_read}, {31'b0, vecs[i].e_read});
            if (vecs[i].e_read)
                checkOutput($sformatf("row%0d_addr", i), inst_mem_address, vecs[i].e_addr);
            checkOutput($sformatf("row%0d_valid", i), {31'b0, if_valid}, {31'b0, vecs[i].e_valid});
            if (vecs[i].e_valid)
                checkOutput($sformatf("row%0d_pc", i), if_pc, vecs[i].e_pc);
            checkOutput($sformatf("row%0d_inst", i), if_inst, vecs[i].e_inst);
            if (vecs[i].push)
                exp_q.push_back('{pc: vecs[i].e_addr, inst: vecs[i].rdata});
            @(posedge clk); #1;
        end

        // Back-to-back fetching: one instruction every two cycles.
        rst = 1'b0; stall = 1'b0; redirect = 1'b0; inst_mem_resp = 1'b0;
        fetch_one(32'hAAAA0001, 32'h64, 0);
        fetch_one(32'hAAAA0002, 32'h68, 1);
        fetch_one(32'hAAAA0003, 32'h6C, 1);

        @(negedge clk);
        @(posedge clk); #1;
        checkOutput("sb_drained", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
